// File: rtl/arc_mem_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arc_mem_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4
    } arb_state_t;

    // Requester identifiers used by the winner select.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data, with a fetch-starvation counter.
// Latency: winner is combinational; the counter updates on the grant edge.
// Backpressure: only grants while i_arb_en (arbiter idle) is high.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_arb_en              arbiter is in IDLE and may grant
//   i_if_pend, i_dm_pend  eligible requests (already masked by lockout)
//   i_if_req              raw fetch request, qualifies starvation counting
//   o_grant_vld           a winner was chosen this cycle
//   o_grant_id            REQ_IF or REQ_DM
module mem_arb_prio
    import arc_mem_pkg::*;
#(
    parameter int IF_STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_arb_en,
    input  logic i_if_pend,
    input  logic i_dm_pend,
    input  logic i_if_req,
    output logic o_grant_vld,
    output logic o_grant_id
);

    localparam int             CW      = $clog2(IF_STARVE_MAX + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(IF_STARVE_MAX);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          force_if;

    // Once data has won CNT_MAX times in a row over a waiting fetch,
    // fetch gets the next slot even if data is still pending.
    assign force_if    = (cnt_q == CNT_MAX);
    assign o_grant_vld = i_arb_en & (i_if_pend | i_dm_pend);
    assign o_grant_id  = (i_if_pend & (~i_dm_pend | force_if)) ? REQ_IF : REQ_DM;

    always_comb begin
        cnt_d = cnt_q;
        if (o_grant_vld) begin
            if (o_grant_id == REQ_IF) begin
                cnt_d = '0;
            end else if (i_if_req && (cnt_q < CNT_MAX)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports, one
// transaction outstanding. Latency: req in IDLE -> o_mem_req next cycle ->
// o_x_valid one cycle after rvalid. Backpressure: o_stall holds the core.
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_if_req/i_if_addr               fetch request (held until o_if_valid)
//   o_if_rdata/o_if_valid            fetch result and one-cycle completion
//   i_dm_req/we/addr/wdata           data request (held until o_dm_valid)
//   o_dm_rdata/o_dm_valid            read data and one-cycle completion
//   o_stall                          freeze the core pipeline
//   o_mem_req/we/addr/wdata          memory request, stable until i_mem_gnt
//   i_mem_gnt/i_mem_rdata/i_mem_rvalid  memory accept and completion
//   o_err                            sticky protocol error
module mem_port_arbiter
    import arc_mem_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int IF_STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic [DW-1:0] o_if_rdata,
    output logic          o_if_valid,
    input  logic          i_dm_req,
    input  logic          i_dm_we,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    output logic [DW-1:0] o_dm_rdata,
    output logic          o_dm_valid,
    output logic          o_stall,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_gnt,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_mem_rvalid,
    output logic          o_err
);

    arb_state_t    state_q, state_d;
    logic [DW-1:0] if_rdata_q, dm_rdata_q;
    logic          if_vld_q, dm_vld_q;
    logic          err_q;
    logic          grant_vld, grant_id;
    logic          in_issue, in_wait;

    // A port whose completion is pulsing this cycle still shows its old
    // request; mask it so the same access is not served twice.
    mem_arb_prio #(
        .IF_STARVE_MAX(IF_STARVE_MAX)
    ) u_prio (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_arb_en   (state_q == IDLE),
        .i_if_pend  (i_if_req & ~if_vld_q),
        .i_dm_pend  (i_dm_req & ~dm_vld_q),
        .i_if_req   (i_if_req),
        .o_grant_vld(grant_vld),
        .o_grant_id (grant_id)
    );

    assign in_issue = (state_q == ISSUE_I) || (state_q == ISSUE_D);
    assign in_wait  = (state_q == WAIT_I)  || (state_q == WAIT_D);

    // Core request inputs are held stable until completion, so the memory
    // request can be driven straight from them while in ISSUE.
    always_comb begin
        state_d     = state_q;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = (grant_id == REQ_IF) ? ISSUE_I : ISSUE_D;
                end
            end
            ISSUE_I: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_if_addr;
                if (i_mem_gnt) state_d = WAIT_I;
            end
            ISSUE_D: begin
                o_mem_req   = 1'b1;
                o_mem_we    = i_dm_we;
                o_mem_addr  = i_dm_addr;
                o_mem_wdata = i_dm_wdata;
                if (i_mem_gnt) state_d = WAIT_D;
            end
            WAIT_I, WAIT_D: begin
                if (i_mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_vld_q   <= 1'b0;
            dm_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            if_vld_q <= (state_q == WAIT_I) && i_mem_rvalid;
            dm_vld_q <= (state_q == WAIT_D) && i_mem_rvalid;
            if ((state_q == WAIT_I) && i_mem_rvalid) begin
                if_rdata_q <= i_mem_rdata;
            end
            // Write completions leave the last read data untouched.
            if ((state_q == WAIT_D) && i_mem_rvalid && !i_dm_we) begin
                dm_rdata_q <= i_mem_rdata;
            end
            if ((i_mem_rvalid && !in_wait) || (i_mem_gnt && !in_issue)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_if_rdata = if_rdata_q;
    assign o_if_valid = if_vld_q;
    assign o_dm_rdata = dm_rdata_q;
    assign o_dm_valid = dm_vld_q;
    assign o_err      = err_q;
    assign o_stall    = (i_if_req & ~if_vld_q) | (i_dm_req & ~dm_vld_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory responder.
// Latency: responder grants after gnt_delay waits, rvalid rv_delay after.
// Backpressure: responder only grants while o_mem_req is high.
module tb_mem_port_arbiter;

    logic        clk;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    logic        i_dm_req;
    logic        i_dm_we;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [31:0] o_dm_rdata;
    logic        o_dm_valid;
    logic        o_stall;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic [31:0] i_mem_rdata;
    logic        i_mem_rvalid;
    logic        o_err;

    int n_checks = 0;
    int n_pass   = 0;

    // responder state
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    int          g_cnt     = 0;
    int          rv_cnt    = 0;
    bit          rv_pend   = 0;
    logic [31:0] resp      = '0;
    logic [31:0] g_addr[$];

    mem_port_arbiter #(.AW(32), .DW(32), .IF_STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_if_valid(o_if_valid),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .o_dm_rdata(o_dm_rdata), .o_dm_valid(o_dm_valid),
        .o_stall(o_stall),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_gnt(i_mem_gnt), .i_mem_rdata(i_mem_rdata),
        .i_mem_rvalid(i_mem_rvalid), .o_err(o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: reads return 0x2402000A at 0x100, else addr^0xA5A50000;
    // write completions return junk that must not reach o_dm_rdata.
    initial begin
        i_mem_gnt    = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            i_mem_gnt    = 1'b0;
            i_mem_rvalid = 1'b0;
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = resp;
                    rv_pend      = 0;
                end else begin
                    rv_cnt--;
                end
            end else if (o_mem_req === 1'b1) begin
                if (g_cnt == gnt_delay) begin
                    i_mem_gnt = 1'b1;
                    g_cnt     = 0;
                    rv_pend   = 1;
                    rv_cnt    = rv_delay;
                    g_addr.push_back(o_mem_addr);
                    if (o_mem_we) resp = 32'hBAD0BAD0;
                    else if (o_mem_addr == 32'h100) resp = 32'h2402000A;
                    else resp = o_mem_addr ^ 32'hA5A50000;
                end else begin
                    g_cnt++;
                end
            end
        end
    end

    // Waits at negedges for a completion pulse; ok=0 if it never comes.
    task automatic wait_valid(input bit is_dm, output bit ok);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if ((is_dm ? o_dm_valid : o_if_valid) === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1; i_if_req = 0; i_if_addr = '0;
        i_dm_req = 0; i_dm_we = 0; i_dm_addr = '0; i_dm_wdata = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        #1;
        n_checks++; if (o_mem_req !== 1'b0) $display("FAIL reset_mem_req got %0h exp 0", o_mem_req); else n_pass++;
        n_checks++; if (o_mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %0h exp 0", o_mem_addr); else n_pass++;
        n_checks++; if ({o_if_valid, o_dm_valid, o_stall, o_err} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {o_if_valid, o_dm_valid, o_stall, o_err}); else n_pass++;
        n_checks++; if ({o_if_rdata, o_dm_rdata} !== 64'h0) $display("FAIL reset_rdata got %0h exp 0", {o_if_rdata, o_dm_rdata}); else n_pass++;
    endtask

    task automatic test_fetch_only;
        @(negedge clk);
        i_if_req = 1; i_if_addr = 32'h100;
        #1;
        n_checks++; if (o_stall !== 1'b1) $display("FAIL fetch_stall_n got %0h exp 1", o_stall); else n_pass++;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_mem_we} !== 2'b10) $display("FAIL fetch_issue got req/we %b exp 10", {o_mem_req, o_mem_we}); else n_pass++;
        n_checks++; if (o_mem_addr !== 32'h100) $display("FAIL fetch_addr got %0h exp 100", o_mem_addr); else n_pass++;
        n_checks++; if (o_mem_wdata !== 32'h0) $display("FAIL fetch_wdata got %0h exp 0", o_mem_wdata); else n_pass++;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_stall, o_if_valid} !== 3'b010) $display("FAIL fetch_wait got req/stall/vld %b exp 010", {o_mem_req, o_stall, o_if_valid}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({o_if_valid, o_stall} !== 2'b10) $display("FAIL fetch_done got vld/stall %b exp 10", {o_if_valid, o_stall}); else n_pass++;
        n_checks++; if (o_if_rdata !== 32'h2402000A) $display("FAIL fetch_rdata got %0h exp 2402000a", o_if_rdata); else n_pass++;
        i_if_req = 0;
        @(negedge clk);
        n_checks++; if ({o_if_valid, o_mem_req} !== 2'b00) $display("FAIL fetch_pulse_end got %b exp 00", {o_if_valid, o_mem_req}); else n_pass++;
        n_checks++; if (o_if_rdata !== 32'h2402000A) $display("FAIL fetch_rdata_hold got %0h exp 2402000a", o_if_rdata); else n_pass++;
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        i_if_req = 1; i_if_addr = 32'h104;
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h200;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 32'h200}) $display("FAIL simul_data_first got req/we %b addr %0h exp 10 200", {o_mem_req, o_mem_we}, o_mem_addr); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if ({o_dm_valid, o_if_valid, o_stall} !== 3'b101) $display("FAIL simul_dm_done got %b exp 101", {o_dm_valid, o_if_valid, o_stall}); else n_pass++;
        n_checks++; if (o_dm_rdata !== 32'hA5A50200) $display("FAIL simul_dm_rdata got %0h exp a5a50200", o_dm_rdata); else n_pass++;
        i_dm_req = 0;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h104}) $display("FAIL simul_fetch_issue got req %0h addr %0h exp 1 104", o_mem_req, o_mem_addr); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if ({o_if_valid, o_dm_valid} !== 2'b10) $display("FAIL simul_if_done_3_after got %b exp 10", {o_if_valid, o_dm_valid}); else n_pass++;
        n_checks++; if (o_if_rdata !== 32'hA5A50104) $display("FAIL simul_if_rdata got %0h exp a5a50104", o_if_rdata); else n_pass++;
        i_if_req = 0;
    endtask

    task automatic test_write_gnt_delay;
        int bad = 0;
        gnt_delay = 3;
        @(negedge clk);
        i_dm_req = 1; i_dm_we = 1; i_dm_addr = 32'h300; i_dm_wdata = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== {2'b11, 32'h300, 32'hDEADBEEF}) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL write_hold_stable got %0d unstable cycles exp 0", bad); else n_pass++;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_dm_valid, o_stall} !== 3'b001) $display("FAIL write_wait got %b exp 001", {o_mem_req, o_dm_valid, o_stall}); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_dm_valid !== 1'b1) $display("FAIL write_done got %0h exp 1", o_dm_valid); else n_pass++;
        n_checks++; if (o_dm_rdata !== 32'hA5A50200) $display("FAIL write_rdata_kept got %0h exp a5a50200", o_dm_rdata); else n_pass++;
        i_dm_req = 0; i_dm_we = 0;
        gnt_delay = 0;
    endtask

    task automatic test_starvation;
        bit ok = 0;
        g_addr.delete();
        @(negedge clk);
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h400;
        i_if_req = 1; i_if_addr = 32'h108;
        // Fetch is withdrawn during each data completion cycle so data is the
        // sole eligible winner at every arbitration until the counter trips.
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_if_valid === 1'b1) begin ok = 1; i_if_req = 0; break; end
            i_if_req = (o_dm_valid === 1'b1) ? 1'b0 : 1'b1;
        end
        n_checks++; if (!ok) $display("FAIL starve_fetch_timeout got no if_valid exp one"); else n_pass++;
        wait_valid(1, ok);
        n_checks++; if (!ok) $display("FAIL starve_tail_timeout got no dm_valid exp one"); else n_pass++;
        i_dm_req = 0;
        n_checks++; if (g_addr.size() != 6) $display("FAIL starve_grant_count got %0d exp 6", g_addr.size()); else n_pass++;
        n_checks++; if ({g_addr[0], g_addr[1], g_addr[2], g_addr[3]} !== {4{32'h400}}) $display("FAIL starve_four_data got %0h %0h %0h %0h exp 400 x4", g_addr[0], g_addr[1], g_addr[2], g_addr[3]); else n_pass++;
        n_checks++; if ({g_addr[4], g_addr[5]} !== {32'h108, 32'h400}) $display("FAIL starve_forced_fetch got %0h %0h exp 108 400", g_addr[4], g_addr[5]); else n_pass++;
        // Counter must be back at 0: with both pending, data wins again.
        @(negedge clk);
        i_dm_req = 1; i_dm_addr = 32'h404; i_if_req = 1; i_if_addr = 32'h10C;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h404}) $display("FAIL starve_cnt_cleared got req %0h addr %0h exp 1 404", o_mem_req, o_mem_addr); else n_pass++;
        wait_valid(1, ok);
        i_dm_req = 0;
        wait_valid(0, ok);
        n_checks++; if (!ok || o_if_rdata !== 32'hA5A5010C) $display("FAIL starve_final_fetch got ok %0d rdata %0h exp 1 a5a5010c", ok, o_if_rdata); else n_pass++;
        i_if_req = 0;
    endtask

    task automatic test_lockout;
        bit ok = 0;
        @(negedge clk);
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h600;
        wait_valid(1, ok);
        n_checks++; if (!ok) $display("FAIL lock_dm_timeout got no dm_valid exp one"); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_mem_req !== 1'b0) $display("FAIL lock_no_reissue got %0h exp 0", o_mem_req); else n_pass++;
        i_dm_req = 0;
        @(negedge clk);
        i_dm_req = 1; i_dm_addr = 32'h604;
        wait_valid(1, ok);
        i_if_req = 1; i_if_addr = 32'h110;
        @(negedge clk);
        n_checks++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 32'h110}) $display("FAIL lock_fetch_instead got req/we %b addr %0h exp 10 110", {o_mem_req, o_mem_we}, o_mem_addr); else n_pass++;
        i_dm_req = 0;
        wait_valid(0, ok);
        n_checks++; if (!ok || o_if_rdata !== 32'hA5A50110) $display("FAIL lock_fetch_rdata got ok %0d rdata %0h exp 1 a5a50110", ok, o_if_rdata); else n_pass++;
        i_if_req = 0;
        n_checks++; if (o_err !== 1'b0) $display("FAIL lock_err_clean got %0h exp 0", o_err); else n_pass++;
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        rv_delay = 5;
        @(negedge clk);
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h500;
        repeat (2) @(negedge clk);
        n_checks++; if (o_mem_req !== 1'b0) $display("FAIL rst_in_wait got req %0h exp 0", o_mem_req); else n_pass++;
        i_rst = 1; i_dm_req = 0;
        @(negedge clk);
        i_rst = 0;
        n_checks++; if ({o_mem_req, o_dm_valid, o_err, o_stall} !== 4'b0) $display("FAIL rst_mid_flags got %b exp 0000", {o_mem_req, o_dm_valid, o_err, o_stall}); else n_pass++;
        n_checks++; if ({o_if_rdata, o_dm_rdata} !== 64'h0) $display("FAIL rst_mid_rdata got %0h exp 0", {o_if_rdata, o_dm_rdata}); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_dm_valid === 1'b1 || o_if_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL rst_late_rvalid_pulse got %0d exp 0", pulses); else n_pass++;
        n_checks++; if (o_err !== 1'b1) $display("FAIL rst_late_rvalid_err got %0h exp 1", o_err); else n_pass++;
        @(negedge clk);
        n_checks++; if (o_err !== 1'b1) $display("FAIL err_sticky got %0h exp 1", o_err); else n_pass++;
        rv_delay = 0;
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_write_gnt_delay();
        test_starvation();
        test_lockout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
